fadd_arbiter: RTL and testbench
===============================

Name: fadd_arbiter

Overview:
- Shares a single floating-point adder (`fadd`-style: operands plus start pulse in, sum plus done pulse out) among NREQ requesters.
- Performs round-robin arbitration over per-requester valid/ready request channels and issues one add at a time to the adder.
- Returns each result to the requester that issued it over a per-requester valid/ready response channel.
- Guards against a hung adder with a timeout counter and counts completed operations.

Parameters:
- W, 32, operand/result width in bits (IEEE single layout).
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 16, maximum cycles to wait for add_done after add_start (>=2).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester request accept (one-hot or zero).
- req_a  input  NREQ*W  flattened operand A; requester i occupies bits [i*W +: W].
- req_b  input  NREQ*W  flattened operand B, same packing.
- rsp_valid  output  NREQ  per-requester response valid (one-hot or zero).
- rsp_ready  input  NREQ  per-requester response accept.
- rsp_sum  output  W  result, shared by all requesters, meaningful only while some rsp_valid bit is high.
- rsp_err  output  1  response is a timeout, not an adder result.
- add_a  output  W  operand A to the adder.
- add_b  output  W  operand B to the adder.
- add_start  output  1  one-cycle issue pulse to the adder.
- add_sum  input  W  adder result.
- add_done  input  1  adder result valid pulse.
- busy  output  1  high in any state other than IDLE.
- op_count  output  16  completed responses, wraps 0xFFFF->0x0000.

Behaviour:
- Reset (synchronous): state=IDLE, last_grant=NREQ-1 (so requester 0 wins first), grant=0, timeout counter=0, op_count=0, and operand/sum registers=0.
  - Registered outputs rsp_sum, rsp_err, add_a, add_b and op_count read 0 after reset.
  - Decoded outputs req_ready, rsp_valid, add_start and busy are 0 while state=IDLE with no request.
- Reset asserted in any state abandons the in-flight operation: no response is produced and a late add_done is ignored.
- IDLE:
  - If any req_valid bit is set, the winner g is the first set bit searching from (last_grant+1) mod NREQ upward, with wrap.
  - req_ready[g]=1 combinationally in that cycle; all other req_ready bits are 0.
  - On the clock edge: add_a<=req_a[g], add_b<=req_b[g], grant<=g, last_grant<=g, state<=ISSUE.
  - req_ready is 0 in every other state.
- ISSUE: add_start=1 for exactly this one cycle; counter<=0; state<=WAIT.
- add_a and add_b stay stable from ISSUE through the end of RESP.
- WAIT:
  - If add_done: rsp_sum<=add_sum, rsp_err<=0, state<=RESP.
  - Else if counter==TIMEOUT-1: rsp_sum<=all ones (NaN pattern), rsp_err<=1, state<=RESP.
  - Else counter increments.
  - If add_done arrives in the same cycle the counter expires, add_done wins and rsp_err=0.
- RESP:
  - rsp_valid[grant]=1; rsp_sum and rsp_err are held stable.
  - When rsp_ready[grant]=1: op_count increments (wrapping), state<=IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
- add_done in IDLE, ISSUE or RESP is ignored and never corrupts rsp_sum.
- Latency: request accepted at edge 0, add_start in cycle 1, rsp_valid in the cycle after add_done.
  - With a 3-cycle adder (done in cycle 4) rsp_valid rises in cycle 5.
  - Minimum accept-to-accept spacing is 4 cycles with an immediate rsp_ready.
- A requester may hold req_valid across its own RESP; it is re-arbitrated in the next IDLE behind all other valid requesters.
- Fairness: with all NREQ requesters continuously valid, grants cycle 0,1,2,...,NREQ-1,0,...
- Counter width is clog2(TIMEOUT) bits; it never exceeds TIMEOUT-1.

Test Plan:
- Single request, adder model with 3-cycle done:
  - Stimulus: requester 2 sends 0x3F800000+0x3F800000.
  - Required: req_ready[2] for 1 cycle, add_start 1 cycle later, rsp_valid=4'b0100 with rsp_sum=0x40000000 and rsp_err=0, op_count=1.
- Contention:
  - Stimulus: all 4 requesters valid continuously, rsp_ready tied high.
  - Required: grant order 0,1,2,3,0,1; each response routed only to its issuer; op_count=6.
- Timeout:
  - Stimulus: adder never asserts add_done, TIMEOUT=16.
  - Required: rsp_valid 16 cycles after the WAIT entry with rsp_sum=0xFFFFFFFF and rsp_err=1; the next request then completes normally.
- Backpressure and stray done:
  - Stimulus: hold rsp_ready low for 10 cycles in RESP and pulse add_done twice.
  - Required: rsp_sum, rsp_err and add_a/add_b are unchanged, no new grant occurs, and completion happens on the first rsp_ready.
- Done coincident with timeout:
  - Stimulus: add_done in the cycle the counter equals TIMEOUT-1.
  - Required: response carries add_sum with rsp_err=0.
- Reset mid-WAIT:
  - Stimulus: assert reset for 1 cycle during WAIT, then the adder asserts add_done.
  - Required: state IDLE, no rsp_valid, op_count=0, and requester 0 wins the next arbitration.

Source files
------------

// File: rtl/fadd_arbiter_if.sv
// fadd_arbiter_if: request/response channels of the requesters plus the shared adder hookup.
interface fadd_arbiter_if #(
  parameter int W    = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_err;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic              add_start;
  logic [W-1:0]      add_sum;
  logic              add_done;
  modport master (
    output req_valid, req_a, req_b, rsp_ready, add_sum, add_done,
    input  req_ready, rsp_valid, rsp_sum, rsp_err, add_a, add_b, add_start
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, add_sum, add_done,
    output req_ready, rsp_valid, rsp_sum, rsp_err, add_a, add_b, add_start
  );
endinterface

// File: rtl/fadd_arbiter.sv
// fadd_arbiter: round-robin sharing of one floating-point adder among NREQ requesters,
// with a hung-adder timeout and a completed-operation counter.
module fadd_arbiter #(
  parameter int W       = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  fadd_arbiter_if.slave    bus,
  output logic             busy,
  output logic [15:0]      op_count
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t        r_state;
  logic [GW-1:0] r_last;
  logic [GW-1:0] r_grant;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_ops;
  logic [W-1:0]  r_add_a;
  logic [W-1:0]  r_add_b;
  logic [W-1:0]  r_sum;
  logic          r_err;
  logic          w_found;
  logic [GW-1:0] w_win;
  // first valid requester strictly after the last grant, wrapping
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NREQ; k++)
      if (!w_found && bus.req_valid[(int'(r_last) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = GW'((int'(r_last) + k) % NREQ);
      end
  end
  assign bus.req_ready = (r_state == IDLE && w_found) ? NREQ'(1) << w_win : '0;
  assign bus.rsp_valid = (r_state == RESP) ? NREQ'(1) << r_grant : '0;
  assign bus.add_start = r_state == ISSUE;
  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.rsp_sum   = r_sum;
  assign bus.rsp_err   = r_err;
  assign busy          = r_state != IDLE;
  assign op_count      = r_ops;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= GW'(NREQ - 1);
      r_grant <= '0;
      r_cnt   <= '0;
      r_ops   <= '0;
      r_add_a <= '0;
      r_add_b <= '0;
      r_sum   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (w_found) begin
            r_add_a <= bus.req_a[int'(w_win)*W +: W];
            r_add_b <= bus.req_b[int'(w_win)*W +: W];
            r_grant <= w_win;
            r_last  <= w_win;
            r_state <= ISSUE;
          end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT:
          if (bus.add_done) begin
            r_sum   <= bus.add_sum;
            r_err   <= 1'b0;
            r_state <= RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_sum   <= '1;
            r_err   <= 1'b1;
            r_state <= RESP;
          end else
            r_cnt <= r_cnt + 1'b1;
        RESP:
          if (bus.rsp_ready[r_grant]) begin
            r_ops   <= r_ops + 16'd1;
            r_state <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fadd_arbiter.sv
// tb_fadd_arbiter: directed and randomized transactions against a round-robin/latency model
// with a stand-in adder whose completion delay is chosen per transaction.
module tb_fadd_arbiter;
  localparam int W = 32, NREQ = 4, TIMEOUT = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic [15:0] op_count;
  int checks = 0, errors = 0;
  int lat = 0, acnt = 0;
  logic [W-1:0] la, lb;
  int exp_last = NREQ - 1;
  logic [15:0] exp_ops = '0;
  fadd_arbiter_if #(.W(W), .NREQ(NREQ)) bus ();
  fadd_arbiter #(.W(W), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .bus(bus), .busy(busy), .op_count(op_count));
  always #5 clock = ~clock;
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  // doubling of equal normal operands is exact; other pairs just need a distinct result
  function automatic logic [W-1:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a == b) ? a + 32'h0080_0000 : a + b;
  endfunction
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    int best = -1, bd = NREQ;
    for (int i = 0; i < NREQ; i++)
      if (v[i] && (i - last - 1 + NREQ) % NREQ < bd) begin
        bd = (i - last - 1 + NREQ) % NREQ;
        best = i;
      end
    return best;
  endfunction
  function automatic logic [NREQ*W-1:0] rand_vec();
    logic [NREQ*W-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i*W +: W] = $urandom;
    return v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #2;
  endtask
  // stand-in adder: done pulse lat cycles after the start cycle; lat==0 never answers
  initial forever begin
    @(posedge clock);
    #1;
    if (lat != 0) begin
      bus.add_done = 1'b0;
      if (acnt > 0) begin
        acnt--;
        if (acnt == 0) begin
          bus.add_done = 1'b1;
          bus.add_sum  = model_sum(la, lb);
        end
      end
      if (bus.add_start) begin
        acnt = lat;
        la = bus.add_a;
        lb = bus.add_b;
      end
    end
  end
  task automatic txn(input logic [NREQ-1:0] mask, input logic [NREQ*W-1:0] a,
                     input logic [NREQ*W-1:0] b, input int l, input int hold);
    int g, n;
    bit to;
    logic [W-1:0] ea, eb, es;
    lat = l; acnt = 0; bus.add_done = 1'b0;
    bus.req_valid = mask; bus.req_a = a; bus.req_b = b; bus.rsp_ready = '0;
    #1;
    g = rr_pick(mask, exp_last);
    exp_last = g;
    ea = a[g*W +: W];
    eb = b[g*W +: W];
    to = (l == 0) || (l > TIMEOUT);
    es = to ? '1 : model_sum(ea, eb);
    chk("req_ready", 32'(bus.req_ready), 1 << g);
    tick();
    bus.req_valid = '0;
    chk("add_start", 32'(bus.add_start), 1);
    chk("add_a", bus.add_a, ea);
    chk("add_b", bus.add_b, eb);
    n = 1;
    while (bus.rsp_valid == '0 && n < 40) begin
      tick();
      n++;
    end
    chk("rsp_latency", n, to ? TIMEOUT + 2 : l + 2);
    chk("rsp_valid", 32'(bus.rsp_valid), 1 << g);
    chk("rsp_sum", bus.rsp_sum, es);
    chk("rsp_err", 32'(bus.rsp_err), 32'(to));
    for (int i = 0; i < hold; i++) begin
      lat = 0;
      bus.add_done = (i == 2 || i == 5);
      bus.add_sum = 32'hDEAD_BEEF;
      bus.req_valid = mask;
      bus.rsp_ready = ~(NREQ'(1) << g);
      tick();
      chk("hold_valid", 32'(bus.rsp_valid), 1 << g);
      chk("hold_sum", bus.rsp_sum, es);
      chk("hold_err", 32'(bus.rsp_err), 32'(to));
      chk("hold_a", bus.add_a, ea);
      chk("hold_b", bus.add_b, eb);
      chk("hold_no_grant", 32'(bus.req_ready), 0);
    end
    bus.add_done = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = NREQ'(1) << g;
    tick();
    exp_ops++;
    chk("op_count", 32'(op_count), 32'(exp_ops));
    chk("idle_busy", 32'(busy), 0);
    chk("idle_rsp_valid", 32'(bus.rsp_valid), 0);
    bus.rsp_ready = '0;
  endtask
  initial begin
    int order[6] = '{0, 1, 2, 3, 0, 1};
    int gq[$];
    int ng, nr, r;
    logic [NREQ*W-1:0] one;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = '0;
    bus.add_done = 1'b0; bus.add_sum = '0;
    repeat (2) tick();
    chk("rst_rsp_sum", bus.rsp_sum, 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_add_a", bus.add_a, 0);
    chk("rst_add_b", bus.add_b, 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_add_start", 32'(bus.add_start), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    one = '0;
    one[2*W +: W] = 32'h3F80_0000;
    txn(4'b0100, one, one, 3, 0);
    chk("single_sum", bus.rsp_sum, 32'h4000_0000);
    txn(4'b1010, rand_vec(), rand_vec(), 0, 0);
    txn(4'b1111, rand_vec(), rand_vec(), 2, 0);
    txn(4'b0001, rand_vec(), rand_vec(), 16, 0);
    txn(4'b0110, rand_vec(), rand_vec(), 17, 3);
    txn(4'b0010, rand_vec(), rand_vec(), 2, 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_last = NREQ - 1;
    exp_ops = '0;
    lat = 1; acnt = 0; bus.add_done = 1'b0;
    bus.req_a = rand_vec(); bus.req_b = rand_vec();
    bus.req_valid = '1; bus.rsp_ready = '1;
    #1;
    ng = 0; nr = 0;
    for (int c = 0; c < 60 && nr < 6; c++) begin
      if (bus.req_ready != '0) begin
        chk("rr_grant", 32'(bus.req_ready), ng < 6 ? 1 << order[ng] : 0);
        gq.push_back(ng < 6 ? order[ng] : 0);
        ng++;
      end
      if (bus.rsp_valid != '0) begin
        if (gq.size() > 0) chk("route", 32'(bus.rsp_valid), 1 << gq.pop_front());
        else chk("route_no_issue", 32'(bus.rsp_valid), 0);
        nr++;
        if (nr == 6) bus.req_valid = '0;
      end
      tick();
    end
    bus.rsp_ready = '0;
    exp_last = 1;
    exp_ops = 16'd6;
    chk("contention_responses", nr, 6);
    chk("contention_op_count", 32'(op_count), 6);
    chk("contention_busy", 32'(busy), 0);
    lat = 3; acnt = 0;
    bus.req_valid = 4'b0100; bus.req_a = rand_vec(); bus.req_b = rand_vec();
    #1;
    chk("rstw_grant", 32'(bus.req_ready), 4);
    tick();
    bus.req_valid = '0;
    chk("rstw_start", 32'(bus.add_start), 1);
    tick();
    chk("rstw_busy_wait", 32'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_last = NREQ - 1;
    exp_ops = '0;
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_op_count", 32'(op_count), 0);
    repeat (3) begin
      tick();
      chk("rstw_no_rsp", 32'(bus.rsp_valid), 0);
      chk("rstw_idle", 32'(busy), 0);
      chk("rstw_sum", bus.rsp_sum, 0);
    end
    txn(4'b1111, rand_vec(), rand_vec(), 3, 0);
    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 9);
      txn(NREQ'($urandom_range(1, 15)), rand_vec(), rand_vec(), r, $urandom_range(0, 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
